lcm_meas_ctrl: RTL and testbench

Measurement sequencer for the dual-counter datapath (two 10-bit modulo counters, equality comparator, Cout-tracking FSM). On a `start` command it loads a modulus pair into the counters and holds them in reset for one cycle. It then releases them and counts clock cycles until both carry-outs fire in the same cycle, which is the LCM coincidence. It reports the period and the per-counter wrap counts. It sits between the host/test logic and the datapath and owns the counters' `Module` inputs and their reset.

---
 rtl/lcm_meas_ctrl.sv | 156 +++++++++++++++
 tb/tb_lcm_meas_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcm_meas_ctrl.sv
// Measurement sequencer for the dual modulo-counter datapath: loads a modulus pair,
// releases the counters and times the first cycle in which both carry-outs coincide.
module lcm_meas_ctrl #(
    parameter int CYC_W = 20
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [9:0]       modA_in,
    input  logic [9:0]       modB_in,
    input  logic             CoutA,
    input  logic             CoutB,
    output logic [9:0]       cntA_Module,
    output logic [9:0]       cntB_Module,
    output logic             cnt_rst_n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             timeout,
    output logic [CYC_W-1:0] period,
    output logic [CYC_W-1:0] wrapsA,
    output logic [CYC_W-1:0] wrapsB
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CYC_W-1:0] CYC_MAX  = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [9:0]       moda_q, moda_d, modb_q, modb_d;
    logic [CYC_W-1:0] cyc_q, cyc_d, cyc_now_s;
    logic [CYC_W-1:0] period_q, period_d, wra_q, wra_d, wrb_q, wrb_d;
    logic             to_q, to_d, busy_q, busy_d, done_q, done_d;
    logic             err_q, err_d, crst_q, crst_d;

    // Next-state and next-output computation; abort wins over any RUN-cycle update.
    always_comb begin
        state_d   = state_q;
        moda_d    = moda_q;
        modb_d    = modb_q;
        cyc_d     = cyc_q;
        period_d  = period_q;
        wra_d     = wra_q;
        wrb_d     = wrb_q;
        to_d      = to_q;
        err_d     = 1'b0;
        cyc_now_s = cyc_q + CYC_ONE;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((modA_in < 10'd2) || (modB_in < 10'd2)) begin
                        err_d = 1'b1;
                    end else begin
                        moda_d   = modA_in;
                        modb_d   = modB_in;
                        cyc_d    = CYC_ZERO;
                        period_d = CYC_ZERO;
                        wra_d    = CYC_ZERO;
                        wrb_d    = CYC_ZERO;
                        to_d     = 1'b0;
                        state_d  = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_now_s;
                    wra_d = wra_q + {{(CYC_W-1){1'b0}}, CoutA};
                    wrb_d = wrb_q + {{(CYC_W-1){1'b0}}, CoutB};
                    // Coincidence takes precedence over saturation in the same cycle.
                    if (CoutA && CoutB) begin
                        period_d = cyc_now_s;
                        state_d  = S_DONE;
                    end else if (cyc_now_s == CYC_MAX) begin
                        period_d = CYC_MAX;
                        to_d     = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
        crst_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            moda_q   <= 10'd0;
            modb_q   <= 10'd0;
            cyc_q    <= CYC_ZERO;
            period_q <= CYC_ZERO;
            wra_q    <= CYC_ZERO;
            wrb_q    <= CYC_ZERO;
            to_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            crst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            moda_q   <= moda_d;
            modb_q   <= modb_d;
            cyc_q    <= cyc_d;
            period_q <= period_d;
            wra_q    <= wra_d;
            wrb_q    <= wrb_d;
            to_q     <= to_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            crst_q   <= crst_d;
        end
    end

    assign cntA_Module = moda_q;
    assign cntB_Module = modb_q;
    assign cnt_rst_n   = crst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign timeout     = to_q;
    assign period      = period_q;
    assign wrapsA      = wra_q;
    assign wrapsB      = wrb_q;

endmodule

// File: tb/tb_lcm_meas_ctrl.sv
// Scoreboard bench for lcm_meas_ctrl with a behavioural model of the two modulo counters.
module tb_lcm_meas_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance, CYC_W = 20
    logic        start = 1'b0, abort = 1'b0;
    logic [9:0]  modA_in = 10'd0, modB_in = 10'd0;
    logic        CoutA, CoutB;
    logic [9:0]  cntA_Module, cntB_Module;
    logic        cnt_rst_n, busy, done, err, timeout;
    logic [19:0] period, wrapsA, wrapsB;

    lcm_meas_ctrl #(.CYC_W(20)) u_dut (
        .CLK(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .modA_in(modA_in), .modB_in(modB_in), .CoutA(CoutA), .CoutB(CoutB),
        .cntA_Module(cntA_Module), .cntB_Module(cntB_Module), .cnt_rst_n(cnt_rst_n),
        .busy(busy), .done(done), .err(err), .timeout(timeout),
        .period(period), .wrapsA(wrapsA), .wrapsB(wrapsB)
    );

    // Narrow instance for the timeout path, CYC_W = 8
    logic        start8 = 1'b0, abort8 = 1'b0;
    logic [9:0]  modA8 = 10'd0, modB8 = 10'd0;
    logic        CoutA8;
    logic        CoutB8 = 1'b0;
    logic [9:0]  cntA8, cntB8;
    logic        crst8, busy8, done8, err8, to8;
    logic [7:0]  period8, wrapsA8, wrapsB8;

    lcm_meas_ctrl #(.CYC_W(8)) u_dut8 (
        .CLK(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .modA_in(modA8), .modB_in(modB8), .CoutA(CoutA8), .CoutB(CoutB8),
        .cntA_Module(cntA8), .cntB_Module(cntB8), .cnt_rst_n(crst8),
        .busy(busy8), .done(done8), .err(err8), .timeout(to8),
        .period(period8), .wrapsA(wrapsA8), .wrapsB(wrapsB8)
    );

    // Datapath model: cnt is 0 in the first released cycle, Cout when cnt == Module-1.
    logic [9:0] ca = 10'd0, cb = 10'd0, ca8 = 10'd0;
    always @(posedge clk) begin
        ca  <= (!cnt_rst_n || ca == cntA_Module - 10'd1) ? 10'd0 : ca + 10'd1;
        cb  <= (!cnt_rst_n || cb == cntB_Module - 10'd1) ? 10'd0 : cb + 10'd1;
        ca8 <= (!crst8 || ca8 == cntA8 - 10'd1) ? 10'd0 : ca8 + 10'd1;
    end
    assign CoutA  = cnt_rst_n && (ca == cntA_Module - 10'd1);
    assign CoutB  = cnt_rst_n && (cb == cntB_Module - 10'd1);
    assign CoutA8 = crst8 && (ca8 == cntA8 - 10'd1);

    typedef struct {
        int per;
        int wa;
        int wb;
        bit aborted;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lcm(input int a, input int b);
        int p;
        p = a;
        while ((p % b) != 0) p += a;
        return p;
    endfunction

    // One measurement; abort_at / poke_at are RUN-cycle numbers (0 = none).
    task automatic run(input int a, input int b, input int abort_at, input int poke_at);
        exp_t e, g;
        int   n_busy, n_rel;
        bit   got;
        n_busy = 0;
        n_rel  = 0;
        got    = 1'b0;
        @(negedge clk);
        modA_in = 10'(a);
        modB_in = 10'(b);
        start   = 1'b1;
        e.aborted = (abort_at != 0);
        e.per = e.aborted ? 0 : lcm(a, b);
        e.wa  = e.aborted ? (abort_at - 1) / a : e.per / a;
        e.wb  = e.aborted ? (abort_at - 1) / b : e.per / b;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check_eq("load_busy", busy, 1);
        check_eq("load_cnt_rst_n", cnt_rst_n, 0);
        check_eq("load_modA", cntA_Module, a);
        check_eq("load_modB", cntB_Module, b);
        for (int i = 1; i < 5000 && !got; i++) begin
            if (busy) n_busy++;
            if (cnt_rst_n) n_rel++;
            if (i == abort_at + 1 && abort_at != 0) abort = 1'b1;
            if (i == poke_at + 1 && poke_at != 0) begin
                start   = 1'b1;
                modA_in = 10'd5;
                modB_in = 10'd6;
            end
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            if (i == poke_at + 1 && poke_at != 0) begin
                check_eq("ignored_start_err", err, 0);
                check_eq("ignored_start_mod", cntA_Module, a);
            end
            if (done || (abort_at != 0 && i == abort_at + 1)) got = 1'b1;
        end
        g = sb.pop_front();
        if (!got) begin
            check_eq("wait_done_budget", 0, 1);
        end else begin
            check_eq("period", period, g.per);
            check_eq("wrapsA", wrapsA, g.wa);
            check_eq("wrapsB", wrapsB, g.wb);
            check_eq("timeout_flag", timeout, 0);
            if (g.aborted) begin
                check_eq("abort_no_done", done, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_cnt_rst_n", cnt_rst_n, 0);
            end else begin
                check_eq("busy_cycles", n_busy, g.per + 1);
                check_eq("release_cycles", n_rel, g.per);
                check_eq("done_cnt_rst_n", cnt_rst_n, 0);
                @(negedge clk);
                check_eq("done_one_cycle", done, 0);
                check_eq("period_hold", period, g.per);
            end
        end
    endtask

    task automatic reject(input int a, input int b, input int keep_per);
        @(negedge clk);
        modA_in = 10'(a);
        modB_in = 10'(b);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("reject_err", err, 1);
        check_eq("reject_busy", busy, 0);
        check_eq("reject_period_kept", period, keep_per);
        @(negedge clk);
        check_eq("reject_err_pulse", err, 0);
        check_eq("reject_still_idle", busy, 0);
    endtask

    initial begin
        int n_rel8;
        bit got8;
        #12;
        check_eq("rst_cnt_rst_n", cnt_rst_n, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_period", period, 0);
        check_eq("rst_modA", cntA_Module, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(3, 4, 0, 0);
        run(7, 7, 0, 0);
        run(31, 32, 0, 0);
        reject(1, 5, 992);
        reject(0, 9, 992);
        run(3, 4, 0, 3);
        run(3, 4, 5, 0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        modA_in = 10'd3;
        modB_in = 10'd4;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_reset_running", cnt_rst_n, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("areset_cnt_rst_n", cnt_rst_n, 0);
        check_eq("areset_busy", busy, 0);
        check_eq("areset_wrapsA", wrapsA, 0);
        check_eq("areset_modB", cntB_Module, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2, 3, 0, 0);

        // Saturation timeout on the narrow instance, CoutB never fires
        n_rel8 = 0;
        got8   = 1'b0;
        @(negedge clk);
        modA8  = 10'd3;
        modB8  = 10'd5;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 400 && !got8; i++) begin
            if (crst8) n_rel8++;
            @(negedge clk);
            if (done8) got8 = 1'b1;
        end
        check_eq("to_reached_done", got8, 1);
        check_eq("to_period", period8, 255);
        check_eq("to_flag", to8, 1);
        check_eq("to_wrapsA", wrapsA8, 85);
        check_eq("to_wrapsB", wrapsB8, 0);
        check_eq("to_run_cycles", n_rel8, 255);
        @(negedge clk);
        modA8  = 10'd3;
        modB8  = 10'd4;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check_eq("to_cleared_on_start", to8, 0);
        check_eq("to_restart_busy", busy8, 1);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        @(negedge clk);
        check_eq("to_abort_idle", busy8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
